psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Sits at the output end of the PE array and consumes the partial-sum stream qualified by the PE controller's p_valid_output / last_chanel_output strobes.
- Accumulates partial sums across input channels into a TILE_LEN-entry buffer, one entry per output column of the tile.
- On the last channel it emits the finished sums through a small output FIFO with a valid/ready handshake.
- On end of convolution it drains the FIFO, then signals done.

Parameters:
- TILE_LEN, 16, accumulator entries per tile row; index wraps at TILE_LEN-1.
- PSUM_W, 24, signed width of incoming partial sum.
- ACC_W, 32, signed accumulator and output width.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start_conv  in  1  pulse; clears buffer state, FIFO, error, and index.
- p_valid  in  1  psum_in valid this cycle.
- last_channel  in  1  qualifies p_valid: final input channel for this entry.
- end_conv  in  1  pulse; no more psums follow.
- psum_in  in  PSUM_W  signed partial sum.
- out_data  out  ACC_W  finished sum at FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after drain completes.
- overflow_err  out  1  sticky; a finished sum was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FIFO empty, idx=0, all entry-valid bits 0, state IDLE.
- State machine:
  - IDLE -> ACCUM on start_conv.
  - ACCUM -> DRAIN on end_conv.
  - DRAIN -> DONE when FIFO is empty (checked the same cycle; an empty FIFO goes to DONE on the next edge).
  - DONE -> IDLE unconditionally; done=1 only in DONE.
  - start_conv in any state -> ACCUM with the full clear. It has priority over p_valid and end_conv in that cycle, and a p_valid in that cycle is ignored.
- Index: idx advances by 1 on each accepted p_valid in ACCUM and wraps from TILE_LEN-1 to 0. The PE controller delivers bursts of exactly TILE_LEN beats per channel.
- Accumulate (p_valid=1, last_channel=0):
  - vbit[idx]=0: buf[idx] <= sext(psum_in), vbit[idx] <= 1.
  - vbit[idx]=1: buf[idx] <= buf[idx] + sext(psum_in).
- Finish (p_valid=1, last_channel=1):
  - sum = (vbit[idx] ? buf[idx] : 0) + sext(psum_in).
  - sum is pushed to the FIFO; vbit[idx] <= 0; buf is not written.
- Arithmetic: two's-complement, wrap modulo 2^ACC_W, no saturation. psum_in is sign-extended to ACC_W.
- Latency: a finished sum appears on out_data with out_valid=1 one cycle after its p_valid edge when the FIFO was empty.
- FIFO rules:
  - Push and pop in the same cycle are both allowed, including when full; a pop frees the slot for that cycle's push.
  - Push while full with no pop: the sum is dropped, overflow_err <= 1, and idx still advances.
  - out_data holds stable while out_valid=1 and out_ready=0.
- p_valid in IDLE, DRAIN, or DONE: ignored, and sticky overflow_err is set because this is a protocol error.
- end_conv with partially accumulated entries (vbit set): those entries are discarded, not emitted.
- rst_n asserted mid-operation: immediate return to the reset state; FIFO contents are lost.

Optional Feature:
- Macro: PSUM_ACC_RELU_EN.
- Defined: finished sums with bit ACC_W-1 set are pushed as 0, and all other sums unchanged. ReLU applies only to the pushed value, never to intermediate buf contents.
- Undefined: raw signed sums are pushed.

Test Plan:
- Three-channel accumulate: start_conv, then 3 bursts of 16 beats with psum_in=idx+1; last_channel only on burst 3; out_ready=1 -> 16 outputs with values 3,6,...,48 in idx order, overflow_err=0.
- Backpressure: single-channel burst (last_channel=1 all 16 beats) with out_ready=0 -> exactly 4 outputs are held; overflow_err=1 from the 5th beat; out_data stays 1 while stalled.
- Signed wrap: ACC_W=32; channel 1 psum=0x7FFFFF (8388607) on all beats, channel 2 (last) psum=-8388608 -> every output is -1 (0xFFFFFFFF); with PSUM_ACC_RELU_EN every output is 0.
- Drain/done: 2 outputs pending, end_conv, out_ready asserted after 5 cycles -> busy=1 until the FIFO is empty, then done pulses exactly 1 cycle and busy=0 the following cycle.
- Restart mid-run: start_conv in the middle of burst 2 together with p_valid -> that beat is dropped, the FIFO is empty, idx=0, and the next 2-channel run produces correct sums with no carry-over.
- Async reset: assert rst_n=0 mid-burst with out_valid=1 -> out_valid, busy, done, and overflow_err all go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/psum_accumulator_if.sv
// Stream and control bundle for psum_accumulator: partial-sum input strobes,
// finished-sum valid/ready output and status flags.
interface psum_accumulator_if #(
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32
);
  logic                     start_conv;
  logic                     p_valid;
  logic                     last_channel;
  logic                     end_conv;
  logic signed [PSUM_W-1:0] psum_in;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     overflow_err;

  modport master (
    output start_conv, p_valid, last_channel, end_conv, psum_in, out_ready,
    input  out_data, out_valid, busy, done, overflow_err
  );

  modport slave (
    input  start_conv, p_valid, last_channel, end_conv, psum_in, out_ready,
    output out_data, out_valid, busy, done, overflow_err
  );
endinterface

// File: rtl/psum_accumulator.sv
// Channel-wise partial-sum accumulator with output FIFO and drain/done sequencing.
// Optional macro PSUM_ACC_RELU_EN clamps negative finished sums to zero on push.
module psum_accumulator #(
  parameter int TILE_LEN   = 16,
  parameter int PSUM_W     = 24,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  psum_accumulator_if.slave bus
);
  localparam int IDX_W = $clog2(TILE_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic signed [ACC_W-1:0] buf_r [TILE_LEN];
  logic [TILE_LEN-1:0]     vbit_r;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s;
  logic signed [ACC_W-1:0] fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r, count_nxt_s;
  logic                    overflow_r, busy_r, done_r, out_valid_r;
  logic                    busy_nxt_s, done_nxt_s;
  logic                    accept_s, proto_err_s, push_s, pop_s, push_ok_s, drop_s;
  logic                    empty_s, full_s;
  logic signed [ACC_W-1:0] psum_ext_s, sum_s;

  function automatic logic signed [ACC_W-1:0] relu_f(input logic signed [ACC_W-1:0] sum);
`ifdef PSUM_ACC_RELU_EN
    if (sum[ACC_W-1]) begin
      relu_f = {ACC_W{1'b0}};
    end else begin
      relu_f = sum;
    end
`else
    relu_f = sum;
`endif
  endfunction

  // Datapath decode: running sum, FIFO push/pop qualification and next index.
  always_comb begin
    psum_ext_s  = ACC_W'(bus.psum_in);
    sum_s       = (vbit_r[idx_r] ? buf_r[idx_r] : {ACC_W{1'b0}}) + psum_ext_s;
    empty_s     = (count_r == CNT_W'(0));
    full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    accept_s    = !bus.start_conv && bus.p_valid && (state_r == ACCUM);
    proto_err_s = !bus.start_conv && bus.p_valid && (state_r != ACCUM);
    pop_s       = !bus.start_conv && bus.out_ready && !empty_s;
    push_s      = accept_s && bus.last_channel;
    // A same-cycle pop frees the slot, so a full FIFO can still take the push.
    push_ok_s   = push_s && (!full_s || pop_s);
    drop_s      = push_s && full_s && !pop_s;
    if (idx_r == IDX_W'(TILE_LEN - 1)) begin
      idx_nxt_s = {IDX_W{1'b0}};
    end else begin
      idx_nxt_s = idx_r + IDX_W'(1);
    end
    if (bus.start_conv) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      count_nxt_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start_conv restarts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.start_conv) begin
      state_nxt_s = ACCUM;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        ACCUM:   state_nxt_s = bus.end_conv ? DRAIN : ACCUM;
        DRAIN:   state_nxt_s = empty_s ? DONE : DRAIN;
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // Registered status outputs and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      out_valid_r <= (count_nxt_s != CNT_W'(0));
      if (bus.start_conv) begin
        overflow_r <= 1'b0;
      end else if (drop_s || proto_err_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Accumulation buffer, entry-valid bits and column index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_LEN; i++) begin
        buf_r[i] <= {ACC_W{1'b0}};
      end
      vbit_r <= {TILE_LEN{1'b0}};
      idx_r  <= {IDX_W{1'b0}};
    end else if (bus.start_conv) begin
      vbit_r <= {TILE_LEN{1'b0}};
      idx_r  <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      idx_r <= idx_nxt_s;
      if (bus.last_channel) begin
        vbit_r[idx_r] <= 1'b0;
      end else begin
        vbit_r[idx_r] <= 1'b1;
        buf_r[idx_r]  <= sum_s;
      end
    end
  end

  // Output FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_r[i] <= {ACC_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (bus.start_conv) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        fifo_r[wr_ptr_r] <= relu_f(sum_s);
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  assign bus.out_data     = fifo_r[rd_ptr_r];
  assign bus.out_valid    = out_valid_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.overflow_err = overflow_r;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed + randomized bench for psum_accumulator against a queue-based
// behavioural model of the accumulate / FIFO / drain rules.
module tb_psum_accumulator;
  localparam int TILE  = 16;
  localparam int DEPTH = 4;
  localparam int PH_IDLE = 0, PH_ACC = 1, PH_DRAIN = 2, PH_DONE = 3;
`ifdef PSUM_ACC_RELU_EN
  localparam logic [31:0] EXP_WRAP = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_WRAP = 32'hFFFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  psum_accumulator_if #(.PSUM_W(24), .ACC_W(32)) bus ();

  psum_accumulator #(
    .TILE_LEN(16), .PSUM_W(24), .ACC_W(32), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          macc [TILE];
  bit          mvld [TILE];
  int          mq [$];
  bit          merr;
  int          midx;
  int          mphase;
  int          n_pops;
  logic [31:0] dut_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int relu(input int s);
`ifdef PSUM_ACC_RELU_EN
    return (s < 0) ? 0 : s;
`else
    return s;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TILE; i++) begin
      macc[i] = 0;
      mvld[i] = 1'b0;
    end
    mq.delete();
    merr = 1'b0;
    midx = 0;
  endtask

  // Apply the current inputs to the model, clock once, compare all outputs.
  task automatic tick();
    int sz0, nxt, sx, s;
    sz0 = mq.size();
    nxt = mphase;
    if (bus.out_valid && bus.out_ready && !bus.start_conv) begin
      dut_last = bus.out_data;
      n_pops++;
    end
    if (bus.start_conv) begin
      model_clear();
      nxt = PH_ACC;
    end else begin
      if (bus.out_ready && sz0 > 0) void'(mq.pop_front());
      if (bus.p_valid) begin
        if (mphase == PH_ACC) begin
          sx = $signed(bus.psum_in);
          s = (mvld[midx] ? macc[midx] : 0) + sx;
          if (bus.last_channel) begin
            mvld[midx] = 1'b0;
            if (mq.size() < DEPTH) mq.push_back(relu(s));
            else merr = 1'b1;
          end else begin
            macc[midx] = s;
            mvld[midx] = 1'b1;
          end
          midx = (midx + 1) % TILE;
        end else begin
          merr = 1'b1;
        end
      end
      case (mphase)
        PH_ACC:   if (bus.end_conv) nxt = PH_DRAIN;
        PH_DRAIN: if (sz0 == 0) nxt = PH_DONE;
        PH_DONE:  nxt = PH_IDLE;
        default:  nxt = mphase;
      endcase
    end
    mphase = nxt;
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) chk("out_data", bus.out_data, mq[0]);
    chk("overflow_err", {31'd0, bus.overflow_err}, {31'd0, merr});
    chk("busy", {31'd0, bus.busy}, {31'd0, mphase != PH_IDLE});
    chk("done", {31'd0, bus.done}, {31'd0, mphase == PH_DONE});
  endtask

  task automatic beat(input int p, input bit last);
    bus.p_valid      = 1'b1;
    bus.last_channel = last;
    bus.psum_in      = p[23:0];
    tick();
    bus.p_valid      = 1'b0;
    bus.last_channel = 1'b0;
  endtask

  task automatic start();
    bus.start_conv = 1'b1;
    tick();
    bus.start_conv = 1'b0;
  endtask

  task automatic end_c();
    bus.end_conv = 1'b1;
    tick();
    bus.end_conv = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      seen = bus.done;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    tick();
  endtask

  initial begin
    bus.start_conv   = 1'b0;
    bus.p_valid      = 1'b0;
    bus.last_channel = 1'b0;
    bus.end_conv     = 1'b0;
    bus.psum_in      = 24'd0;
    bus.out_ready    = 1'b0;
    model_clear();
    mphase   = PH_IDLE;
    n_pops   = 0;
    dut_last = 32'd0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.overflow_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // p_valid while idle is a protocol error
    beat(5, 1'b0);
    chk("idle_pvalid_err", {31'd0, bus.overflow_err}, 32'd1);

    // three-channel accumulate, free-flowing output
    bus.out_ready = 1'b1;
    start();
    n_pops = 0;
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < TILE; i++) beat(i + 1, ch == 2);
    end_c();
    wait_done();
    chk("tc_count", n_pops, 32'd16);
    chk("tc_last", dut_last, 32'd48);
    chk("tc_err", {31'd0, bus.overflow_err}, 32'd0);

    // backpressure: four held, rest dropped
    bus.out_ready = 1'b0;
    start();
    for (int i = 0; i < TILE; i++) beat(i + 1, 1'b1);
    chk("bp_head", bus.out_data, 32'd1);
    chk("bp_err", {31'd0, bus.overflow_err}, 32'd1);

    // drain with two pending and late ready
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    end_c();
    repeat (5) tick();
    chk("drain_busy", {31'd0, bus.busy}, 32'd1);
    chk("drain_head", bus.out_data, 32'd3);
    bus.out_ready = 1'b1;
    wait_done();
    chk("drain_idle", {31'd0, bus.busy}, 32'd0);

    // signed wrap across two channels
    start();
    n_pops = 0;
    for (int i = 0; i < TILE; i++) beat(8388607, 1'b0);
    for (int i = 0; i < TILE; i++) beat(-8388608, 1'b1);
    end_c();
    wait_done();
    chk("wrap_count", n_pops, 32'd16);
    chk("wrap_last", dut_last, EXP_WRAP);

    // restart mid-burst with a concurrent p_valid, then a random 2-channel run
    start();
    for (int i = 0; i < TILE; i++) beat(int'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) beat(int'($urandom), 1'b0);
    bus.start_conv = 1'b1;
    bus.p_valid    = 1'b1;
    bus.psum_in    = 24'h12_3456;
    tick();
    bus.start_conv = 1'b0;
    bus.p_valid    = 1'b0;
    chk("rs_empty", {31'd0, bus.out_valid}, 32'd0);
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < TILE; i++) begin
        bus.out_ready = ($urandom_range(3) != 0);
        beat(int'($urandom), ch == 1);
      end
    bus.out_ready = 1'b1;
    end_c();
    wait_done();

    // asynchronous reset mid-burst
    bus.out_ready = 1'b0;
    start();
    for (int i = 0; i < 6; i++) beat(i + 1, 1'b1);
    chk("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.p_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_busy", {31'd0, bus.busy}, 32'd0);
    chk("ar_done", {31'd0, bus.done}, 32'd0);
    chk("ar_err", {31'd0, bus.overflow_err}, 32'd0);
    bus.p_valid = 1'b0;
    model_clear();
    mphase = PH_IDLE;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
